// File: rtl/lib_switchblock_pkg.sv
// rtl/lib_switchblock_pkg.sv - shared types and constants for the DEM-DAC switch-block path
package lib_switchblock_pkg;

  localparam int NSQ_INPUT_WIDTH  = 16;
  localparam int NSQ_OUTPUT_WIDTH = 3;

  typedef enum logic [1:0] {ORD0, ORD1, ORD2} order_e;
  typedef enum logic [1:0] {RUN, SAT, RECOVER} nsq_state_e;

  function automatic int nsq_step(input int in_w, input int out_w);
    return 1 << (in_w - out_w);
  endfunction

  function automatic int nsq_offset(input int in_w);
    return 1 << (in_w - 1);
  endfunction

endpackage

// File: rtl/ns_quant_core.sv
// rtl/ns_quant_core.sv - combinational mid-rise quantizer: loop value to code, reconstruction, clamped error
module ns_quant_core
  import lib_switchblock_pkg::*;
#(
  parameter int INPUT_WIDTH  = NSQ_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = NSQ_OUTPUT_WIDTH
) (
  input  logic signed [INPUT_WIDTH+2:0] i_v,
  output logic        [OUTPUT_WIDTH-1:0] o_code,
  output logic signed [INPUT_WIDTH+2:0] o_yq,
  output logic signed [INPUT_WIDTH-1:0] o_err,
  output logic                          o_sat
);

  localparam int VW    = INPUT_WIDTH + 3;
  localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam logic signed [VW-1:0] STEP_V     = VW'(nsq_step(INPUT_WIDTH, OUTPUT_WIDTH));
  localparam logic signed [VW-1:0] OFFSET_V   = VW'(nsq_offset(INPUT_WIDTH));
  localparam logic signed [VW-1:0] HALF_V     = STEP_V >>> 1;
  localparam logic signed [VW-1:0] CODE_MAX_V = VW'((1 << OUTPUT_WIDTH) - 1);
  localparam logic signed [VW-1:0] ERR_MAX_V  = HALF_V - VW'(1);
  localparam logic signed [VW-1:0] ERR_MIN_V  = -HALF_V;

  logic signed [VW-1:0] w_raw;
  logic signed [VW-1:0] w_code;
  logic signed [VW-1:0] w_err_full;

  // Arithmetic shift gives floor division for negative loop values too
  assign w_raw = (i_v + OFFSET_V) >>> SHIFT;

  always_comb begin
    w_code = w_raw;
    o_sat  = 1'b0;
    if (w_raw[VW-1]) begin
      w_code = '0;
      o_sat  = 1'b1;
    end else if (w_raw > CODE_MAX_V) begin
      w_code = CODE_MAX_V;
      o_sat  = 1'b1;
    end
  end

  assign o_code     = w_code[OUTPUT_WIDTH-1:0];
  assign o_yq       = (w_code <<< SHIFT) - OFFSET_V + HALF_V;
  assign w_err_full = i_v - o_yq;

  always_comb begin
    o_err = w_err_full[INPUT_WIDTH-1:0];
    if (o_sat) begin
      if (w_err_full > ERR_MAX_V) begin
        o_err = ERR_MAX_V[INPUT_WIDTH-1:0];
      end else if (w_err_full < ERR_MIN_V) begin
        o_err = ERR_MIN_V[INPUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/ns_quantizer.sv
// rtl/ns_quantizer.sv - error-feedback noise-shaping quantizer with order select and overload recovery
module ns_quantizer
  import lib_switchblock_pkg::*;
#(
  parameter int INPUT_WIDTH  = NSQ_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = NSQ_OUTPUT_WIDTH,
  parameter int OVL_LIMIT    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  input  logic signed [INPUT_WIDTH-1:0] x_in_i,
  input  logic        [1:0]             order_i,
  output logic                          valid_o,
  output logic        [OUTPUT_WIDTH-1:0] quantized_out_o,
  output logic signed [INPUT_WIDTH-1:0] quant_error_o,
  output logic                          sat_o,
  output logic                          overload_o
);

  localparam int VW = INPUT_WIDTH + 3;
  localparam int CW = $clog2(OVL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(OVL_LIMIT);

  logic signed [INPUT_WIDTH-1:0] r_e1, r_e2;
  order_e                        r_order;
  nsq_state_e                    r_state;
  logic [CW-1:0]                 r_sat_cnt;
  logic                          r_valid, r_sat, r_ovl;
  logic [OUTPUT_WIDTH-1:0]       r_code;
  logic signed [INPUT_WIDTH-1:0] r_err;

  order_e                        w_order;
  logic                          w_flush;
  logic signed [INPUT_WIDTH-1:0] w_e1, w_e2;
  logic signed [VW-1:0]          w_x_ext, w_e1_ext, w_e2_ext, w_v, w_yq;
  logic [OUTPUT_WIDTH-1:0]       w_code;
  logic signed [INPUT_WIDTH-1:0] w_err;
  logic                          w_sat;
  logic [CW-1:0]                 w_cnt_inc;

  assign w_order = (order_i == 2'd0) ? ORD0 : (order_i == 2'd1) ? ORD1 : ORD2;
  // A new order would otherwise inherit history shaped by a different NTF
  assign w_flush = (w_order != r_order);
  assign w_e1    = w_flush ? '0 : r_e1;
  assign w_e2    = w_flush ? '0 : r_e2;

  assign w_x_ext  = VW'(x_in_i);
  assign w_e1_ext = VW'(w_e1);
  assign w_e2_ext = VW'(w_e2);

  always_comb begin
    w_v = w_x_ext;
    case (w_order)
      ORD1:    w_v = w_x_ext + w_e1_ext;
      ORD2:    w_v = w_x_ext + (w_e1_ext <<< 1) - w_e2_ext;
      default: w_v = w_x_ext;
    endcase
  end

  ns_quant_core #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_core (
    .i_v   (w_v),
    .o_code(w_code),
    .o_yq  (w_yq),
    .o_err (w_err),
    .o_sat (w_sat)
  );

  assign w_cnt_inc = r_sat_cnt + CW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_err     <= '0;
      r_sat     <= 1'b0;
      r_ovl     <= 1'b0;
      r_e1      <= '0;
      r_e2      <= '0;
      r_order   <= ORD0;
      r_state   <= RUN;
      r_sat_cnt <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_code  <= w_code;
        r_err   <= w_err;
        r_sat   <= w_sat;
        r_ovl   <= 1'b0;
        r_order <= w_order;
        r_e2    <= w_e1;
        r_e1    <= w_err;
        case (r_state)
          SAT: begin
            if (w_sat && (w_cnt_inc >= LIMIT_C)) begin
              r_state   <= RECOVER;
              r_sat_cnt <= '0;
              r_ovl     <= 1'b1;
              r_e1      <= '0;
              r_e2      <= '0;
            end else if (w_sat) begin
              r_sat_cnt <= w_cnt_inc;
            end else begin
              r_state   <= RUN;
              r_sat_cnt <= '0;
            end
          end
          default: begin
            // RECOVER behaves like RUN once its zero-history sample is processed
            if (w_sat && (LIMIT_C == CW'(1))) begin
              r_state   <= RECOVER;
              r_sat_cnt <= '0;
              r_ovl     <= 1'b1;
              r_e1      <= '0;
              r_e2      <= '0;
            end else if (w_sat) begin
              r_state   <= SAT;
              r_sat_cnt <= CW'(1);
            end else begin
              r_state   <= RUN;
              r_sat_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

  assign valid_o         = r_valid;
  assign quantized_out_o = r_code;
  assign quant_error_o   = r_err;
  assign sat_o           = r_sat;
  assign overload_o      = r_ovl;

  // Unsaturated samples must report the exact loop error against the reconstruction level
  a_err_exact : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !w_sat) |-> ((w_v - w_yq) == VW'(w_err)));

endmodule

// File: tb/tb_ns_quantizer.sv
// tb/tb_ns_quantizer.sv - scoreboard bench for ns_quantizer against an integer reference model
module tb_ns_quantizer;

  localparam int IW  = 16;
  localparam int OW  = 3;
  localparam int OVL = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [IW-1:0] x_in_i;
  logic [1:0]    order_i;
  logic          valid_o;
  logic [OW-1:0] quantized_out_o;
  logic [IW-1:0] quant_error_o;
  logic          sat_o;
  logic          overload_o;

  ns_quantizer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .OVL_LIMIT(OVL)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .x_in_i         (x_in_i),
    .order_i        (order_i),
    .valid_o        (valid_o),
    .quantized_out_o(quantized_out_o),
    .quant_error_o  (quant_error_o),
    .sat_o          (sat_o),
    .overload_o     (overload_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int code;
    int err;
    int sat;
    int ovl;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  int m_e1, m_e2, m_order, m_cnt;
  int h_code, h_err, h_sat, h_ovl;

  always @(posedge clk_i) cyc++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_e1 = 0; m_e2 = 0; m_order = 0; m_cnt = 0;
  endtask

  task automatic model_push(input int x, input int ord);
    int o, e1, e2, v, c, code, yq, e, sat, ovl;
    exp_t it;
    o = (ord == 3) ? 2 : ord;
    if (o != m_order) begin e1 = 0; e2 = 0; end
    else begin e1 = m_e1; e2 = m_e2; end
    if (o == 0) v = x;
    else if (o == 1) v = x + e1;
    else v = x + 2 * e1 - e2;
    c = floor_div(v + 32768, 8192);
    sat = 0;
    code = c;
    if (c < 0) begin code = 0; sat = 1; end
    if (c > 7) begin code = 7; sat = 1; end
    yq = code * 8192 - 32768 + 4096;
    e = v - yq;
    if (sat != 0) begin
      if (e > 4095) e = 4095;
      if (e < -4096) e = -4096;
    end
    ovl = 0;
    if (sat != 0) begin
      m_cnt = m_cnt + 1;
      if (m_cnt >= OVL) begin ovl = 1; m_cnt = 0; end
    end else begin
      m_cnt = 0;
    end
    if (ovl != 0) begin m_e1 = 0; m_e2 = 0; end
    else begin m_e2 = e1; m_e1 = e; end
    m_order = o;
    it.code = code; it.err = e; it.sat = sat; it.ovl = ovl; it.cyc = cyc + 1;
    sb.push_back(it);
  endtask

  task automatic send(input int x, input int ord, input int gap);
    model_push(x, ord);
    valid_i = 1'b1;
    x_in_i  = IW'(x);
    order_i = 2'(ord);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(valid_o), 0);
    check_eq({tag, "_code"}, int'(quantized_out_o), 0);
    check_eq({tag, "_err"}, int'($signed(quant_error_o)), 0);
    check_eq({tag, "_sat"}, int'(sat_o), 0);
    check_eq({tag, "_ovl"}, int'(overload_o), 0);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observable before the next edge
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    sb.delete();
    model_reset();
    h_code = 0; h_err = 0; h_sat = 0; h_ovl = 0;
    #1;
    check_zero_outputs(tag);
    valid_i = 1'b1;
    x_in_i  = IW'(12345);
    order_i = 2'd2;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("latency_cycle", cyc, e.cyc);
          check_eq("code", int'(quantized_out_o), e.code);
          check_eq("err", int'($signed(quant_error_o)), e.err);
          check_eq("sat", int'(sat_o), e.sat);
          check_eq("ovl", int'(overload_o), e.ovl);
          h_code = e.code; h_err = e.err; h_sat = e.sat; h_ovl = e.ovl;
        end
      end else begin
        check_eq("hold_code", int'(quantized_out_o), h_code);
        check_eq("hold_err", int'($signed(quant_error_o)), h_err);
        check_eq("hold_sat", int'(sat_o), h_sat);
        check_eq("hold_ovl", int'(overload_o), h_ovl);
      end
    end
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    x_in_i  = '0;
    order_i = 2'd0;
    model_reset();
    h_code = 0; h_err = 0; h_sat = 0; h_ovl = 0;
    #2;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    send(0, 0, 0);
    send(-32768, 0, 0);
    send(32767, 0, 1);

    do_reset("rst_a");
    for (int i = 0; i < 8; i++) send(0, 1, 0);

    do_reset("rst_b");
    for (int i = 0; i < 8; i++) send(0, 2, 0);

    do_reset("rst_c");
    for (int i = 0; i < 10; i++) send(32767, 1, 0);
    for (int i = 0; i < 6; i++) send(-32768, 2, 0);

    do_reset("rst_d");
    for (int i = 0; i < 6; i++) send(0, 1, 2);

    for (int i = 0; i < 5; i++) send(0, 2, 0);
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) send(0, 2, 0);

    for (int i = 0; i < 3; i++) send(1000, 1, 0);
    for (int i = 0; i < 3; i++) send(1000, 2, 1);
    do_reset("rst_e");
    for (int i = 0; i < 4; i++) send(0, 3, 0);

    for (int i = 0; i < 200; i++) begin
      int x;
      if (i < 100) x = int'($urandom_range(65535)) - 32768;
      else x = int'($urandom_range(16383)) - 8192;
      send(x, int'($urandom_range(2)), int'($urandom_range(1)));
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk_i); #1;
    end
    check_eq("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
